// File: rtl/pxs_vga_sync_gen_pkg.sv
// rtl/pxs_vga_sync_gen_pkg.sv - default VGA 640x480 timing constants and coordinate type
package pxs_vga_sync_gen_pkg;

    localparam int COORD_W = 10;
    localparam int MAX_TOT = 1 << COORD_W;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam bit VGA_HS_POL = 1'b0;
    localparam bit VGA_VS_POL = 1'b0;

    typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/pxs_vga_sync_gen_if.sv
// rtl/pxs_vga_sync_gen_if.sv - VGA component bundle handed to the stream-join stage
interface pxs_vga_sync_gen_if;
    import pxs_vga_sync_gen_pkg::*;

    logic   HSync;
    logic   VSync;
    coord_t XCoord;
    coord_t YCoord;
    logic   ActiveVideo;
    logic   line_start;
    logic   frame_start;

    modport master (
        output HSync, VSync, XCoord, YCoord, ActiveVideo, line_start, frame_start
    );

    modport slave (
        input HSync, VSync, XCoord, YCoord, ActiveVideo, line_start, frame_start
    );

endinterface

// File: rtl/pxs_sync_axis.sv
// rtl/pxs_sync_axis.sv - one scan axis: wrapping counter plus sync-window and active decode
module pxs_sync_axis
    import pxs_vga_sync_gen_pkg::*;
#(
    parameter int ACTIVE = VGA_H_ACTIVE,
    parameter int FP     = VGA_H_FP,
    parameter int SYNC   = VGA_H_SYNC,
    parameter int BP     = VGA_H_BP,
    parameter bit POL    = VGA_HS_POL
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   i_ce,
    output coord_t o_pos,
    output logic   o_sync,
    output logic   o_active,
    output logic   o_wrap
);

    localparam int TOT = ACTIVE + FP + SYNC + BP;

    generate
        if (TOT > MAX_TOT || TOT < 2) begin : g_bad_total
            $error("pxs_sync_axis: total %0d outside 2..%0d", TOT, MAX_TOT);
        end
    endgenerate

    // One extra bit so window edges equal to 1024 still compare correctly.
    localparam logic [COORD_W:0] ACT_END  = (COORD_W+1)'(ACTIVE);
    localparam logic [COORD_W:0] SYNC_BEG = (COORD_W+1)'(ACTIVE + FP);
    localparam logic [COORD_W:0] SYNC_END = (COORD_W+1)'(ACTIVE + FP + SYNC);
    localparam coord_t           LAST     = COORD_W'(TOT - 1);

    coord_t             r_cnt;
    logic [COORD_W:0]   w_pos_x;

    assign w_pos_x  = {1'b0, r_cnt};
    assign o_pos    = r_cnt;
    assign o_wrap   = (r_cnt == LAST);
    assign o_active = (w_pos_x < ACT_END);
    assign o_sync   = ((w_pos_x >= SYNC_BEG) && (w_pos_x < SYNC_END)) ? POL : ~POL;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_ce) begin
            r_cnt <= o_wrap ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pxs_vga_sync_gen.sv
// rtl/pxs_vga_sync_gen.sv - VGA timing generator with registered, mutually aligned outputs
module pxs_vga_sync_gen
    import pxs_vga_sync_gen_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit HS_POL   = VGA_HS_POL,
    parameter bit VS_POL   = VGA_VS_POL
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pix_ce,
    pxs_vga_sync_gen_if.master     vga
);

    coord_t w_h;
    coord_t w_v;
    logic   w_h_sync;
    logic   w_v_sync;
    logic   w_h_active;
    logic   w_v_active;
    logic   w_h_wrap;
    logic   w_v_ce;
    logic   w_v_wrap_unused;

    assign w_v_ce = pix_ce && w_h_wrap;

    pxs_sync_axis #(
        .ACTIVE (H_ACTIVE), .FP (H_FP), .SYNC (H_SYNC), .BP (H_BP), .POL (HS_POL)
    ) u_h_axis (
        .clk      (clk),
        .reset    (reset),
        .i_ce     (pix_ce),
        .o_pos    (w_h),
        .o_sync   (w_h_sync),
        .o_active (w_h_active),
        .o_wrap   (w_h_wrap)
    );

    pxs_sync_axis #(
        .ACTIVE (V_ACTIVE), .FP (V_FP), .SYNC (V_SYNC), .BP (V_BP), .POL (VS_POL)
    ) u_v_axis (
        .clk      (clk),
        .reset    (reset),
        .i_ce     (w_v_ce),
        .o_pos    (w_v),
        .o_sync   (w_v_sync),
        .o_active (w_v_active),
        .o_wrap   (w_v_wrap_unused)
    );

    coord_t r_x;
    coord_t r_y;
    logic   r_active;
    logic   r_hsync;
    logic   r_vsync;
    logic   r_line_start;
    logic   r_frame_start;

    // Outputs capture the pre-increment counter state, so every field describes the same pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x           <= '0;
            r_y           <= '0;
            r_active      <= 1'b0;
            r_hsync       <= ~HS_POL;
            r_vsync       <= ~VS_POL;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            if (pix_ce) begin
                r_x           <= w_h;
                r_y           <= w_v;
                r_active      <= w_h_active && w_v_active;
                r_hsync       <= w_h_sync;
                r_vsync       <= w_v_sync;
                r_line_start  <= (w_h == '0);
                r_frame_start <= (w_h == '0) && (w_v == '0);
            end
        end
    end

    assign vga.XCoord      = r_x;
    assign vga.YCoord      = r_y;
    assign vga.ActiveVideo = r_active;
    assign vga.HSync       = r_hsync;
    assign vga.VSync       = r_vsync;
    assign vga.line_start  = r_line_start;
    assign vga.frame_start = r_frame_start;

endmodule
